// File: rtl/ccl_sq_enc_if.sv
// Symbol-FIFO read port and serial codeword bit stream of the CCL sequence encoder.
// The encoder takes the master side; the FIFO and bit consumer take the slave side.
interface ccl_sq_enc_if;
  logic [3:0] rdata;
  logic       rempty;
  logic       rinc;
  logic       bit_out;
  logic       bit_valid;
  logic       bit_ready;

  modport master (
    input  rdata, rempty, bit_ready,
    output rinc, bit_out, bit_valid
  );

  modport slave (
    output rdata, rempty, bit_ready,
    input  rinc, bit_out, bit_valid
  );
endinterface

// File: rtl/ccl_sq_enc.sv
// Canonical-Huffman encoder for the CCL symbol sequence: pops symbols, looks up the codeword,
// shifts it out MSB first and stops once the decoder-side length count reaches SYM_TOTAL.
module ccl_sq_enc #(
  parameter int SYM_TOTAL = 45,
  parameter int TBL_N     = 16,
  parameter int MAX_LEN   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [4*TBL_N-1:0]     CCL_code_sq,
  input  logic [4*MAX_LEN-1:0]   CCL_count_sq,
  ccl_sq_enc_if.master           bus,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [5:0]             sym_count
);

  localparam int IW = $clog2(TBL_N);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam logic [5:0] TOTAL_W = 6'(SYM_TOTAL);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_LOOKUP, S_SHIFT, S_DONE, S_ERR
  } state_t;

  state_t             state, state_next;
  logic               ext;
  logic [MAX_LEN-1:0] shreg;
  logic [LW-1:0]      bit_cnt;

  logic               hit;
  logic [IW-1:0]      idx;
  logic [LW-1:0]      len;
  logic [MAX_LEN-1:0] code;
  logic [MAX_LEN-1:0] shreg_load;
  logic [7:0]         total, base, cnt;
  logic [MAX_LEN-1:0] first_code;
  logic [5:0]         inc;
  logic               rinc, load, shift, clear;

  // Table lookup on the popped symbol; lowest valid index wins, so search from the top down.
  // NOTE: every variable written here gets a default first, otherwise latches would be inferred.
  always_comb begin
    total      = '0;
    base       = '0;
    cnt        = '0;
    first_code = '0;
    hit        = 1'b0;
    idx        = '0;
    len        = '0;
    code       = '0;
    for (int l = 1; l <= MAX_LEN; l++)
      total = total + {4'b0, CCL_count_sq[4*l-4 +: 4]};
    for (int i = TBL_N - 1; i >= 0; i--) begin
      if (8'(i) < total && CCL_code_sq[4*i +: 4] == bus.rdata) begin
        hit = 1'b1;
        idx = IW'(i);
      end
    end
    for (int l = 1; l <= MAX_LEN; l++) begin
      cnt = {4'b0, CCL_count_sq[4*l-4 +: 4]};
      if (hit && len == '0 && 8'(idx) < base + cnt) begin
        len  = LW'(l);
        code = first_code + MAX_LEN'(8'(idx) - base);
      end
      base       = base + cnt;
      first_code = (first_code + MAX_LEN'(cnt)) << 1;
    end
    shreg_load = code << (MAX_LEN - int'(len));
  end

  // Length-count contribution, mirroring the decoder's repeat-extension rules.
  always_comb begin
    inc = 6'd0;
    if (bus.rdata <= 4'd7)
      inc = ext ? 6'(bus.rdata) + 6'd3 : 6'd1;
    else if (bus.rdata == 4'd8)
      inc = 6'd1;
  end

  always_comb begin
    state_next = state;
    rinc       = 1'b0;
    load       = 1'b0;
    shift      = 1'b0;
    clear      = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          clear      = 1'b1;
          state_next = S_READ;
        end
      end
      S_READ: begin
        if (!bus.rempty) begin
          rinc       = 1'b1;
          state_next = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (!hit || len == '0) begin
          state_next = S_ERR;
        end else begin
          load       = 1'b1;
          state_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (bus.bit_ready) begin
          shift = 1'b1;
          if (bit_cnt == LW'(1))
            state_next = (sym_count >= TOTAL_W) ? S_DONE : S_READ;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so every reader sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      sym_count <= '0;
      ext       <= 1'b0;
      shreg     <= '0;
      bit_cnt   <= '0;
    end else begin
      state <= state_next;
      if (clear) begin
        sym_count <= '0;
        ext       <= 1'b0;
      end
      if (load) begin
        sym_count <= sym_count + inc;
        ext       <= (bus.rdata == 4'd9);
        shreg     <= shreg_load;
        bit_cnt   <= len;
      end
      if (shift) begin
        shreg   <= shreg << 1;
        bit_cnt <= bit_cnt - LW'(1);
      end
    end
  end

  assign bus.rinc      = rinc;
  assign bus.bit_valid = (state == S_SHIFT);
  assign bus.bit_out   = shreg[MAX_LEN-1];
  assign busy          = (state == S_READ) || (state == S_LOOKUP) || (state == S_SHIFT);
  assign done          = (state == S_DONE);
  assign err           = (state == S_ERR);

endmodule

// File: tb/tb_ccl_sq_enc.sv
// Self-checking bench for ccl_sq_enc: FIFO model, expected-bit and expected-count scoreboards.
module tb_ccl_sq_enc;

  logic        clk;
  logic        rst;
  logic        start;
  logic [63:0] code_sq;
  logic [15:0] count_sq;
  logic        busy, done, err;
  logic [5:0]  sym_count;

  ccl_sq_enc_if bus ();

  ccl_sq_enc dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .CCL_code_sq  (code_sq),
    .CCL_count_sq (count_sq),
    .bus          (bus),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .sym_count    (sym_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_err    = 0;
  int n_checks = 0;

  logic [3:0] fifo[$];
  logic       exp_bits[$];
  logic [5:0] exp_cnt[$];

  int rinc_cnt   = 0;
  int bit_total  = 0;
  int extra_bits = 0;
  int extra_cnt  = 0;
  int cyc        = 0;
  int ready_mode = 0;
  bit env_on     = 1'b0;
  bit hold_chk   = 1'b1;
  int model_cnt  = 0;
  bit model_ext  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expected codewords for the fixed test table: 0->0, 8->10, 9->110, 2->1110, 7->1111.
  task automatic push_sym(input logic [3:0] s);
    logic [3:0] cw;
    int len;
    int inc;
    cw  = 4'b0000;
    len = 0;
    case (s)
      4'd0: begin cw = 4'b0000; len = 1; end
      4'd8: begin cw = 4'b0010; len = 2; end
      4'd9: begin cw = 4'b0110; len = 3; end
      4'd2: begin cw = 4'b1110; len = 4; end
      4'd7: begin cw = 4'b1111; len = 4; end
      default: len = 0;
    endcase
    fifo.push_back(s);
    for (int b = len - 1; b >= 0; b--) exp_bits.push_back(cw[b]);
    if (len == 0) return;
    if (s <= 4'd7)       inc = model_ext ? int'(s) + 3 : 1;
    else if (s == 4'd8)  inc = 1;
    else                 inc = 0;
    if (inc != 0) begin
      model_cnt = (model_cnt + inc) % 64;
      exp_cnt.push_back(6'(model_cnt));
    end
    model_ext = (s == 4'd9);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    if (model_cnt != 0) exp_cnt.push_back(6'd0);
    model_cnt = 0;
    model_ext = 1'b0;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int k = 0; k < 3000 && !done && !err; k++) @(negedge clk);
    check({tag, "_done"}, 32'(done), 1);
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 2000 && (fifo.size() != 0 || exp_bits.size() != 0); k++) @(negedge clk);
    check({tag, "_drain"}, exp_bits.size(), 0);
    cycles(3);
  endtask

  // Environment: samples at negedge, updates FIFO/ready #1 after posedge.
  initial begin
    logic s_rinc, s_bv, s_bo, s_br;
    logic p_bv, p_bo, p_br;
    logic [5:0] prev_sc;
    bus.rdata     = 4'd0;
    bus.rempty    = 1'b1;
    bus.bit_ready = 1'b1;
    wait (env_on);
    prev_sc = sym_count;
    p_bv = 1'b0; p_bo = 1'b0; p_br = 1'b1;
    forever begin
      @(negedge clk);
      s_rinc = bus.rinc;
      s_bv   = bus.bit_valid;
      s_bo   = bus.bit_out;
      s_br   = bus.bit_ready;
      if (hold_chk && p_bv && !p_br) begin
        check("hold_valid", 32'(s_bv), 1);
        check("hold_bit", 32'(s_bo), 32'(p_bo));
      end
      if (sym_count != prev_sc) begin
        if (exp_cnt.size() == 0) extra_cnt++;
        else check("sym_count_step", 32'(sym_count), 32'(exp_cnt.pop_front()));
      end
      prev_sc = sym_count;
      p_bv = s_bv; p_bo = s_bo; p_br = s_br;
      @(posedge clk);
      #1;
      if (s_rinc) begin
        rinc_cnt++;
        if (fifo.size() > 0) bus.rdata = fifo.pop_front();
      end
      if (s_bv && s_br) begin
        bit_total++;
        if (exp_bits.size() == 0) extra_bits++;
        else check("bit", 32'(s_bo), 32'(exp_bits.pop_front()));
      end
      cyc++;
      bus.rempty = (fifo.size() == 0);
      case (ready_mode)
        1:       bus.bit_ready = (cyc % 3 == 0);
        2:       bus.bit_ready = 1'b0;
        default: bus.bit_ready = 1'b1;
      endcase
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    int r0;
    rst      = 1'b1;
    start    = 1'b0;
    code_sq  = 64'h0000_0000_0007_2980;
    count_sq = 16'h2111;
    cycles(3);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_rinc", 32'(bus.rinc), 0);
    check("rst_valid", 32'(bus.bit_valid), 0);
    check("rst_bit", 32'(bus.bit_out), 0);
    check("rst_count", 32'(sym_count), 0);
    rst    = 1'b0;
    env_on = 1'b1;
    cycles(2);

    // 45 zeros: one "0" bit each.
    do_start();
    b0 = bit_total; r0 = rinc_cnt;
    repeat (45) push_sym(4'd0);
    wait_done("zeros");
    check("zeros_count", 32'(sym_count), 45);
    check("zeros_busy", 32'(busy), 0);
    check("zeros_bits", bit_total - b0, 45);
    cycles(5);
    check("zeros_rinc", rinc_cnt - r0, 45);

    // {9,7}x4 then 8x5.
    do_start();
    b0 = bit_total;
    repeat (4) begin push_sym(4'd9); push_sym(4'd7); end
    repeat (5) push_sym(4'd8);
    wait_done("ext");
    check("ext_count", 32'(sym_count), 45);
    check("ext_bits", bit_total - b0, 38);
    check("ext_steps_left", exp_cnt.size(), 0);

    // Throttled ready during "1110".
    do_start();
    ready_mode = 1;
    b0 = bit_total; r0 = rinc_cnt;
    push_sym(4'd2);
    drain("ready");
    check("ready_bits", bit_total - b0, 4);
    check("ready_rinc", rinc_cnt - r0, 1);
    check("ready_busy", 32'(busy), 1);
    ready_mode = 0;

    // Empty FIFO mid-stream, then resume.
    repeat (20) push_sym(4'd0);
    drain("stall_pre");
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("stall_rinc", 32'(bus.rinc), 0);
      check("stall_valid", 32'(bus.bit_valid), 0);
    end
    repeat (24) push_sym(4'd0);
    @(negedge clk);
    check("resume_rinc", 32'(bus.rinc), 1);
    wait_done("stall");
    check("stall_count", 32'(sym_count), 45);

    // Unknown symbol.
    do_start();
    b0 = bit_total; r0 = rinc_cnt;
    push_sym(4'd5);
    for (int k = 0; k < 50 && !bus.rinc; k++) @(negedge clk);
    check("err_pop", 32'(bus.rinc), 1);
    @(negedge clk);
    check("err_lookup", 32'(err), 0);
    @(negedge clk);
    check("err_set", 32'(err), 1);
    cycles(5);
    check("err_rinc", rinc_cnt - r0, 1);
    check("err_bits", bit_total - b0, 0);
    check("err_busy", 32'(busy), 0);
    check("err_sticky", 32'(err), 1);
    do_start();
    check("restart_count", 32'(sym_count), 0);
    check("restart_err", 32'(err), 0);
    check("restart_busy", 32'(busy), 1);

    // 44 zeros then 9,7 overshoots to 54.
    repeat (44) push_sym(4'd0);
    push_sym(4'd9);
    push_sym(4'd7);
    wait_done("over");
    check("over_count", 32'(sym_count), 54);
    check("over_bits_left", exp_bits.size(), 0);

    // Reset while shifting.
    do_start();
    hold_chk   = 1'b0;
    ready_mode = 2;
    push_sym(4'd7);
    for (int k = 0; k < 50 && !bus.bit_valid; k++) @(negedge clk);
    check("shift_reached", 32'(bus.bit_valid), 1);
    rst = 1'b1;
    exp_cnt.push_back(6'd0);
    @(negedge clk);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_done", 32'(done), 0);
    check("mid_rst_err", 32'(err), 0);
    check("mid_rst_rinc", 32'(bus.rinc), 0);
    check("mid_rst_valid", 32'(bus.bit_valid), 0);
    check("mid_rst_bit", 32'(bus.bit_out), 0);
    check("mid_rst_count", 32'(sym_count), 0);
    rst = 1'b0;
    exp_bits.delete();
    model_cnt  = 0;
    model_ext  = 1'b0;
    ready_mode = 0;
    cycles(3);

    check("extra_bits", extra_bits, 0);
    check("extra_count_steps", extra_cnt, 0);
    check("count_steps_left", exp_cnt.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
